uart_top: RTL and testbench

UART_TOP -- requirements
Module: uart_top

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_gen.sv | 37 +++
 rtl/uart_top.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_top.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and state encodings for the 8N1 UART.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Width of one data character.
    localparam int DATA_W = 8;

    // Oversample ticks per serial bit.
    localparam int OVS = 16;

    // Transmitter state codes (visible on SEG[7:4]).
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Receiver state codes (visible on SEG[3:0]).
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Oversample tick generator. Emits a one-cycle tick every DIV
//                clocks; clr holds the phase at zero so a frame always starts
//                on a fresh tick boundary.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_gen #(
    parameter int DIV = 163
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int                CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = !clr && (cnt == CNT_MAX);

    // Divider counter: restarts on clear and after every tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_top.sv
`default_nettype none
// ============================================================================
//  Module      : uart_top
//  Description : Independent 8N1 UART transmitter and receiver with 16x
//                oversampling, button-triggered transmit and a state-code
//                debug output.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_top
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 19200
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              rx,
    input  logic              BOTON_START,
    input  logic [DATA_W-1:0] SWITCH,
    output logic              tx,
    output logic [DATA_W-1:0] DOUT,
    output logic [7:0]        SEG
);

    // Rounded clocks per oversample tick.
    localparam int DIV = (CLK_HZ + 8 * BAUD) / (16 * BAUD);

    localparam logic [3:0] TICK_LAST = 4'(OVS - 1);
    localparam logic [3:0] TICK_MID  = 4'(OVS / 2 - 1);
    localparam logic [2:0] BIT_LAST  = 3'(DATA_W - 1);

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic btn_meta, btn_sync, btn_prev;
    logic rx_meta, rx_sync;
    logic send_req;

    assign send_req = btn_sync && !btn_prev;

    // Two-flop synchronizers plus edge-detect history; rx idles high.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            btn_prev <= 1'b0;
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
        end else begin
            btn_meta <= BOTON_START;
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Tick generators: each side restarts its phase while idle
    // ------------------------------------------------------------------
    tx_state_t tx_state, tx_next;
    rx_state_t rx_state, rx_next;
    logic      tx_tick, rx_tick;

    uart_baud_gen #(.DIV(DIV)) u_tx_baud (
        .clk   (CLK),
        .rst_n (RESET),
        .clr   (tx_state == TX_IDLE),
        .tick  (tx_tick)
    );

    uart_baud_gen #(.DIV(DIV)) u_rx_baud (
        .clk   (CLK),
        .rst_n (RESET),
        .clr   (rx_state == RX_IDLE),
        .tick  (rx_tick)
    );

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    logic [3:0]        tx_tick_cnt;
    logic [2:0]        tx_bit_cnt;
    logic [DATA_W-1:0] tx_shreg;
    logic              tx_bit_end;

    assign tx_bit_end = tx_tick && (tx_tick_cnt == TICK_LAST);

    // TX state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    // TX next-state: requests outside IDLE are simply dropped.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (send_req) tx_next = TX_START;
            TX_START: if (tx_bit_end) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_end && (tx_bit_cnt == BIT_LAST)) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_end) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX line level decoded from state; idle and stop are high.
    always_comb begin
        tx = 1'b1;
        case (tx_state)
            TX_START: tx = 1'b0;
            TX_DATA:  tx = tx_shreg[0];
            default:  tx = 1'b1;
        endcase
    end

    // TX datapath: latch byte on request, count ticks, shift out LSB first.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            tx_shreg    <= '0;
        end else if (tx_state == TX_IDLE) begin
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
            if (send_req) begin
                tx_shreg <= SWITCH;
            end
        end else if (tx_tick) begin
            tx_tick_cnt <= tx_tick_cnt + 4'd1;
            if ((tx_tick_cnt == TICK_LAST) && (tx_state == TX_DATA)) begin
                tx_shreg   <= {1'b0, tx_shreg[DATA_W-1:1]};
                tx_bit_cnt <= tx_bit_cnt + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [3:0]        rx_tick_cnt;
    logic [2:0]        rx_bit_cnt;
    logic [DATA_W-1:0] rx_shreg;
    logic              rx_armed;

    // RX state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_state <= RX_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    // RX next-state: start-bit check at its midpoint, then full-bit steps.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_armed && !rx_sync) rx_next = RX_START;
            RX_START: if (rx_tick && (rx_tick_cnt == TICK_MID))
                          rx_next = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && (rx_tick_cnt == TICK_LAST) && (rx_bit_cnt == BIT_LAST))
                          rx_next = RX_STOP;
            RX_STOP:  if (rx_tick && (rx_tick_cnt == TICK_LAST)) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: sample at mid-bit, assemble LSB first, commit on good stop.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_shreg    <= '0;
            rx_armed    <= 1'b0;
            DOUT        <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    rx_tick_cnt <= '0;
                    rx_bit_cnt  <= '0;
                    if (rx_sync) rx_armed <= 1'b1;
                end
                RX_START: begin
                    if (rx_tick) begin
                        rx_tick_cnt <= (rx_tick_cnt == TICK_MID) ? 4'd0 : rx_tick_cnt + 4'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_tick) begin
                        rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        if (rx_tick_cnt == TICK_LAST) begin
                            rx_shreg   <= {rx_sync, rx_shreg[DATA_W-1:1]};
                            rx_bit_cnt <= rx_bit_cnt + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick) begin
                        rx_tick_cnt <= rx_tick_cnt + 4'd1;
                        if (rx_tick_cnt == TICK_LAST) begin
                            if (rx_sync) DOUT <= rx_shreg;
                            rx_armed <= 1'b0;
                        end
                    end
                end
                default: rx_tick_cnt <= '0;
            endcase
        end
    end

    // Debug status: state codes zero-extended into each nibble.
    always_comb begin
        SEG = {2'b00, tx_state, 2'b00, rx_state};
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_top
//  Description : Self-checking bench for uart_top with a fast line rate.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_top;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 781_250;
    localparam int DIV    = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
    localparam int BIT    = 16 * DIV;
    localparam int FRAME  = 10 * BIT;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       rx = 1'b1;
    logic       BOTON_START = 1'b0;
    logic [7:0] SWITCH = 8'h00;
    wire        tx;
    wire  [7:0] DOUT;
    wire  [7:0] SEG;

    always #5 CLK = ~CLK;

    uart_top #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .rx          (rx),
        .BOTON_START (BOTON_START),
        .SWITCH      (SWITCH),
        .tx          (tx),
        .DOUT        (DOUT),
        .SEG         (SEG)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] last_good = 8'h00;

    logic       tx_smp[FRAME];
    logic [3:0] txseg_smp[FRAME];
    int         fall_latency;
    bit         got_start;
    logic [3:0] rx_mid_seg;

    // Request a frame, wait (bounded) for the start bit, record one frame.
    task automatic capture_tx(input logic [7:0] sw, input int pulse_at, input logic [7:0] sw2);
        @(negedge CLK);
        SWITCH = sw;
        BOTON_START = 1'b1;
        tx_q.push_back(sw);
        @(negedge CLK);
        BOTON_START = 1'b0;
        fall_latency = 1;
        got_start = 0;
        while (fall_latency <= 20) begin
            if (tx === 1'b0) begin
                got_start = 1;
                break;
            end
            @(negedge CLK);
            fall_latency++;
        end
        if (got_start) begin
            for (int c = 0; c < FRAME; c++) begin
                tx_smp[c]    = tx;
                txseg_smp[c] = SEG[7:4];
                if (c == pulse_at) begin
                    SWITCH = sw2;
                    BOTON_START = 1'b1;
                end else if (c == pulse_at + 1) begin
                    BOTON_START = 1'b0;
                end
                @(negedge CLK);
            end
        end
    endtask

    function automatic logic [7:0] decode_tx();
        logic [7:0] b;
        for (int j = 0; j < 8; j++) b[j] = tx_smp[(j + 1) * BIT + BIT / 2];
        return b;
    endfunction

    // Drive one 8N1 frame on rx; grab RX state code in the middle of the data.
    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            for (int c = 0; c < BIT; c++) begin
                if (i == 4 && c == BIT / 2) rx_mid_seg = SEG[3:0];
                @(negedge CLK);
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        #100;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++; if (DOUT !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", DOUT); end
        n_checks++; if (SEG !== 8'h00) begin n_fail++; $display("FAIL reset_seg: got %h want 00", SEG); end
        @(negedge CLK);
        RESET = 1'b1;
        repeat (50) @(negedge CLK);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL idle_tx: got %b want 1", tx); end
        n_checks++; if (DOUT !== 8'h00) begin n_fail++; $display("FAIL idle_dout: got %h want 00", DOUT); end
        n_checks++; if (SEG !== 8'h00) begin n_fail++; $display("FAIL idle_seg: got %h want 00", SEG); end
    endtask

    task automatic test_transmit();
        logic [9:0] fr;
        logic [7:0] exp_b, obs;
        logic [3:0] exp_seg;
        int bad;
        capture_tx(8'h35, -1, 8'h00);
        exp_b = tx_q.pop_front();
        n_checks++;
        if (!got_start || fall_latency > 4) begin
            n_fail++; $display("FAIL tx_latency: got %0d cycles (started %0d) want <=4", fall_latency, got_start);
        end
        if (got_start) begin
            fr = {1'b1, exp_b, 1'b0};
            for (int i = 0; i < 10; i++) begin
                bad = 0;
                for (int c = i * BIT; c < (i + 1) * BIT; c++) if (tx_smp[c] !== fr[i]) bad++;
                n_checks++;
                if (bad != 0) begin n_fail++; $display("FAIL tx_bit%0d: %0d of %0d cycles differ from %b", i, bad, BIT, fr[i]); end
                exp_seg = (i == 0) ? 4'd1 : (i == 9) ? 4'd3 : 4'd2;
                n_checks++;
                if (txseg_smp[i * BIT + BIT / 2] !== exp_seg) begin
                    n_fail++; $display("FAIL tx_seg_bit%0d: got %0d want %0d", i, txseg_smp[i * BIT + BIT / 2], exp_seg);
                end
            end
            obs = decode_tx();
            n_checks++; if (obs !== exp_b) begin n_fail++; $display("FAIL tx_byte: got %h want %h", obs, exp_b); end
        end
        n_checks++;
        if (tx !== 1'b1 || SEG[7:4] !== 4'd0) begin n_fail++; $display("FAIL tx_end_idle: tx %b seg %0d want 1/0", tx, SEG[7:4]); end
    endtask

    task automatic test_button_during_tx();
        logic [7:0] exp_b, obs;
        int lows;
        capture_tx(8'h35, 3 * BIT + 10, 8'hFF);
        exp_b = tx_q.pop_front();
        obs = got_start ? decode_tx() : 8'hxx;
        n_checks++; if (obs !== exp_b) begin n_fail++; $display("FAIL busy_byte: got %h want %h", obs, exp_b); end
        n_checks++;
        if (!got_start || tx_smp[9 * BIT + BIT / 2] !== 1'b1) begin n_fail++; $display("FAIL busy_stop: got %b want 1", tx_smp[9 * BIT + BIT / 2]); end
        lows = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (tx !== 1'b1) lows++;
            @(negedge CLK);
        end
        n_checks++; if (lows != 0) begin n_fail++; $display("FAIL busy_no_second_frame: %0d low cycles want 0", lows); end
    endtask

    task automatic test_receive();
        logic [7:0] exp_b;
        rx_q.push_back(8'hA5);
        drive_rx(8'hA5, 1'b1);
        exp_b = rx_q.pop_front();
        last_good = exp_b;
        n_checks++; if (DOUT !== exp_b) begin n_fail++; $display("FAIL rx_dout: got %h want %h", DOUT, exp_b); end
        n_checks++; if (rx_mid_seg !== 4'd2) begin n_fail++; $display("FAIL rx_seg_data: got %0d want 2", rx_mid_seg); end
        n_checks++; if (SEG[3:0] !== 4'd0) begin n_fail++; $display("FAIL rx_seg_idle: got %0d want 0", SEG[3:0]); end
    endtask

    task automatic test_glitch_framing();
        logic [7:0] exp_b;
        logic [3:0] seg_mid;
        rx = 1'b0;
        for (int c = 0; c < 5 * DIV; c++) begin
            if (c == 10) seg_mid = SEG[3:0];
            @(negedge CLK);
        end
        rx = 1'b1;
        repeat (2 * BIT) @(negedge CLK);
        n_checks++; if (seg_mid !== 4'd1) begin n_fail++; $display("FAIL glitch_seg_start: got %0d want 1", seg_mid); end
        n_checks++; if (DOUT !== last_good) begin n_fail++; $display("FAIL glitch_dout: got %h want %h", DOUT, last_good); end
        n_checks++; if (SEG[3:0] !== 4'd0) begin n_fail++; $display("FAIL glitch_seg_idle: got %0d want 0", SEG[3:0]); end
        // Framing error: byte must be discarded.
        rx_q.push_back(last_good);
        drive_rx(8'h3C, 1'b0);
        rx = 1'b1;
        repeat (BIT) @(negedge CLK);
        exp_b = rx_q.pop_front();
        n_checks++; if (DOUT !== exp_b) begin n_fail++; $display("FAIL framing_dout: got %h want %h", DOUT, exp_b); end
        // Receiver must re-arm after the line returns high.
        rx_q.push_back(8'h5A);
        drive_rx(8'h5A, 1'b1);
        exp_b = rx_q.pop_front();
        last_good = exp_b;
        n_checks++; if (DOUT !== exp_b) begin n_fail++; $display("FAIL rearm_dout: got %h want %h", DOUT, exp_b); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp_b, obs;
        int w;
        @(negedge CLK);
        SWITCH = 8'h35;
        BOTON_START = 1'b1;
        @(negedge CLK);
        BOTON_START = 1'b0;
        w = 0;
        while (tx !== 1'b0 && w < 20) begin
            @(negedge CLK);
            w++;
        end
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rst_mid_start: tx %b want 0", tx); end
        repeat (2 * BIT + BIT / 2) @(negedge CLK);
        n_checks++;
        if (tx !== 1'b0 || SEG[7:4] !== 4'd2) begin n_fail++; $display("FAIL rst_mid_pre: tx %b seg %0d want 0/2", tx, SEG[7:4]); end
        RESET = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
        n_checks++; if (SEG !== 8'h00) begin n_fail++; $display("FAIL rst_mid_seg: got %h want 00", SEG); end
        n_checks++; if (DOUT !== 8'h00) begin n_fail++; $display("FAIL rst_mid_dout: got %h want 00", DOUT); end
        last_good = 8'h00;
        repeat (5) @(negedge CLK);
        RESET = 1'b1;
        repeat (10) @(negedge CLK);
        capture_tx(8'hC3, -1, 8'h00);
        exp_b = tx_q.pop_front();
        obs = got_start ? decode_tx() : 8'hxx;
        n_checks++; if (obs !== exp_b) begin n_fail++; $display("FAIL rst_after_byte: got %h want %h", obs, exp_b); end
        n_checks++;
        if (!got_start || tx_smp[9 * BIT + BIT / 2] !== 1'b1 || tx_smp[BIT / 2] !== 1'b0) begin
            n_fail++; $display("FAIL rst_after_frame: started %0d start %b stop %b want 1/0/1", got_start, tx_smp[BIT / 2], tx_smp[9 * BIT + BIT / 2]);
        end
    endtask

    initial begin
        test_reset();
        test_transmit();
        test_button_during_tx();
        test_receive();
        test_glitch_framing();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
